// File: rtl/fp_arith_pkg.sv
// Shared constants and helpers for the double-precision arithmetic datapath.
package fp_arith_pkg;
    localparam int DP_MANT_W      = 53;
    localparam int DP_MANT_PROD_W = 106;
    localparam int DEF_SEG_W      = 13;

    // Number of segments needed to cover width bits, seg_w bits at a time.
    function automatic int nseg(input int width, input int seg_w);
        return (width + seg_w - 1) / seg_w;
    endfunction
endpackage

// File: rtl/adder_seg_stage.sv
// One carry-segment of the pipelined adder: a plain SEG_W-bit ripple add.
module adder_seg_stage
    import fp_arith_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a_seg,
    input  logic [SEG_W-1:0] b_seg,
    input  logic             cin,
    output logic [SEG_W-1:0] s_seg,
    output logic             cout
);
    assign {cout, s_seg} = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, cin};
endmodule

// File: rtl/pipelined_segment_adder.sv
// WIDTH-bit adder/subtractor split into SEG_W-bit segments, one segment per stage,
// carry registered between stages; valid/ready handshake with a global stall.
module pipelined_segment_adder
    import fp_arith_pkg::*;
#(
    parameter int WIDTH = DP_MANT_PROD_W,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NSEG = nseg(WIDTH, SEG_W);

    if (SEG_W < 1 || SEG_W > WIDTH) begin : g_bad_param
        $error("pipelined_segment_adder: SEG_W must be in 1..WIDTH");
    end

    logic             advance;
    logic [NSEG:1]    vld_pipe;
    logic [WIDTH-1:0] b_eff;

    assign advance   = !vld_pipe[NSEG] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[NSEG];
    assign b_eff     = sub ? ~b : b;

    // Bubbles travel down the pipe as invalid entries; nothing is collapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (advance) begin
            vld_pipe[1] <= in_valid;
            for (int k = 2; k <= NSEG; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int LO = k * SEG_W;
        localparam int SW = (k == NSEG - 1) ? WIDTH - LO : SEG_W;
        localparam int HI = LO + SW;

        logic [SW-1:0] a_seg, b_seg, s_seg;
        logic          ci, co;
        logic [HI-1:0] sum_d, sum_q;
        logic          cy_q;

        if (k == 0) begin : g_in
            assign a_seg = a[SW-1:0];
            assign b_seg = b_eff[SW-1:0];
            assign ci    = sub | cin;
            assign sum_d = s_seg;
        end else begin : g_in
            assign a_seg = g_stg[k-1].g_up.a_q[SW-1:0];
            assign b_seg = g_stg[k-1].g_up.b_q[SW-1:0];
            assign ci    = g_stg[k-1].cy_q;
            assign sum_d = {s_seg, g_stg[k-1].sum_q};
        end

        adder_seg_stage #(.SEG_W(SW)) u_add (
            .a_seg (a_seg),
            .b_seg (b_seg),
            .cin   (ci),
            .s_seg (s_seg),
            .cout  (co)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                cy_q  <= 1'b0;
            end else if (advance) begin
                sum_q <= sum_d;
                cy_q  <= co;
            end
        end

        // Operand bits still waiting for a later segment (b already conditioned).
        if (HI < WIDTH) begin : g_up
            logic [WIDTH-HI-1:0] a_d, b_d, a_q, b_q;

            if (k == 0) begin : g_src
                assign a_d = a[WIDTH-1:HI];
                assign b_d = b_eff[WIDTH-1:HI];
            end else begin : g_src
                assign a_d = g_stg[k-1].g_up.a_q[WIDTH-LO-1:SW];
                assign b_d = g_stg[k-1].g_up.b_q[WIDTH-LO-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    assign sum  = g_stg[NSEG-1].sum_q;
    assign cout = g_stg[NSEG-1].cy_q;
endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Directed + table-driven bench for pipelined_segment_adder (default, 26/13 and 64/64 configs).
module tb_pipelined_segment_adder;
    localparam int W    = 106;
    localparam int NSEG = 9;

    logic         clk, rst_n;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;

    logic          s_in_valid, s_in_ready, s_out_valid, s_cout;
    logic [25:0]   s_a, s_b, s_sum;
    logic          t_in_valid, t_in_ready, t_out_valid, t_cout, t_cin, t_sub;
    logic [63:0]   t_a, t_b, t_sum;
    logic          one;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    logic [W:0] q[$];

    pipelined_segment_adder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    pipelined_segment_adder #(.WIDTH(26), .SEG_W(13)) dut26 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(1'b0), .sub(1'b0), .out_valid(s_out_valid),
        .out_ready(one), .sum(s_sum), .cout(s_cout)
    );

    pipelined_segment_adder #(.WIDTH(64), .SEG_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .a(t_a), .b(t_b), .cin(t_cin), .sub(t_sub), .out_valid(t_out_valid),
        .out_ready(one), .sum(t_sum), .cout(t_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + 107'd1;
        else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return r;
    endfunction

    // Transfers are decided at the next rising edge; inputs are stable by the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    chk("stream_result", {cout, sum}, q.pop_front());
                    n_out++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic rnd_beat();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        a = t[W-1:0];
        t = {$urandom, $urandom, $urandom, $urandom};
        b = t[W-1:0];
        if ($urandom_range(3) == 0) b = ~a;
        cin = 1'($urandom_range(1));
        sub = 1'($urandom_range(1));
    endtask

    task automatic drain();
        int c;
        c = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_empty", 128'(q.size()), 0);
    endtask

    typedef struct {
        string        nm;
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t tv[9];

    initial begin
        logic [W-1:0] ones, msb, cap_s;
        logic         cap_c;
        int           lat, cnt, gaps, stalls, acc, cyc, out0;

        ones = '1;
        msb  = '0;
        msb[W-1] = 1'b1;
        tv[0] = '{"full_ripple",  ones,           '0,             1'b1, 1'b0, '0,           1'b1};
        tv[1] = '{"sub_7_5",      106'd7,         106'd5,         1'b1, 1'b1, 106'd2,       1'b1};
        tv[2] = '{"sub_5_7",      106'd5,         106'd7,         1'b1, 1'b1, ones - 1,     1'b0};
        tv[3] = '{"add_small",    106'd1,         106'd2,         1'b0, 1'b0, 106'd3,       1'b0};
        tv[4] = '{"ones_ones",    ones,           ones,           1'b1, 1'b0, ones,         1'b1};
        tv[5] = '{"sub_equal",    106'h123,       106'h123,       1'b0, 1'b1, '0,           1'b1};
        tv[6] = '{"sub_0_1",      '0,             106'd1,         1'b0, 1'b1, ones,         1'b0};
        tv[7] = '{"top_seg_cy",   msb,            msb,            1'b0, 1'b0, '0,           1'b1};
        tv[8] = '{"seg0_boundary",106'h1FFF,      106'd1,         1'b0, 1'b0, 106'h2000,    1'b0};

        clk = 0; rst_n = 0; one = 1;
        in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 0;
        s_in_valid = 0; s_a = '0; s_b = '0;
        t_in_valid = 0; t_a = '0; t_b = '0; t_cin = 0; t_sub = 0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 6; i++) begin
            rnd_beat();
            in_valid  = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            @(posedge clk); #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_sum", sum, 0);
            chk("rst_cout", cout, 0);
            chk("rst_in_ready", in_ready, 1);
        end
        in_valid = 0; out_ready = 1;
        rst_n = 1;
        @(posedge clk); #1;

        // Table: one beat into an empty pipe, check latency and value.
        for (int i = 0; i < 9; i++) begin
            a = tv[i].a; b = tv[i].b; cin = tv[i].cin; sub = tv[i].sub;
            in_valid = 1;
            @(posedge clk); #1;
            in_valid = 0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk({tv[i].nm, "_latency"}, 128'(lat), NSEG);
            chk({tv[i].nm, "_sum"}, sum, tv[i].s);
            chk({tv[i].nm, "_cout"}, cout, tv[i].co);
            @(posedge clk); #1;
        end
        drain();

        // Backpressure: fill the pipe with out_ready low.
        out_ready = 0; in_valid = 1;
        cnt = 0;
        rnd_beat(); #1;
        while (in_ready && cnt < 30) begin
            @(posedge clk); #1;
            rnd_beat(); #1;
            cnt++;
        end
        chk("bp_fill_valid", out_valid, 1);
        cap_s = sum; cap_c = cout;
        for (int i = 0; i < 5; i++) begin
            rnd_beat(); #1;
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
            chk("bp_sum_stable", sum, cap_s);
            chk("bp_cout_stable", cout, cap_c);
            chk("bp_valid_held", out_valid, 1);
        end
        // Full pipe, consume and accept on the same edge.
        out_ready = 1; #1;
        chk("full_simul_ready", in_ready, 1);
        @(posedge clk); #1;
        drain();

        // Reset in the middle of operation with results waiting.
        out_ready = 0; in_valid = 1; cnt = 0;
        while (in_ready && cnt < 30) begin
            rnd_beat();
            @(posedge clk); #1;
            cnt++;
        end
        chk("midrst_pre_valid", out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("midrst_valid_drop", out_valid, 0);
        chk("midrst_sum_clear", sum, 0);
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        rst_n = 1;
        out0 = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) out0++;
        end
        chk("midrst_no_output", 128'(out0), 0);

        // Back-to-back streaming with out_ready held high.
        cnt = n_out; gaps = 0; stalls = 0;
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 1000; i++) begin
            rnd_beat(); #1;
            if (!in_ready) stalls++;
            @(posedge clk); #1;
            if (i + 1 >= NSEG && !out_valid) gaps++;
        end
        chk("stream_stalls", 128'(stalls), 0);
        chk("stream_gaps", 128'(gaps), 0);
        drain();
        chk("stream_count", 128'(n_out - cnt), 1000);

        // Random valid and out_ready.
        cnt = n_out; acc = 0; cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            rnd_beat();
            in_valid  = ($urandom_range(3) != 0);
            out_ready = 1'($urandom_range(1));
            #1;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand_accepted", 128'(acc), 1000);
        drain();
        chk("rand_count", 128'(n_out - cnt), 1000);

        // Narrow configurations.
        s_a = 26'h3FFFFFF; s_b = 26'd1; s_in_valid = 1;
        t_a = '1; t_b = '0; t_cin = 1; t_sub = 0; t_in_valid = 1;
        @(posedge clk); #1;
        s_in_valid = 0;
        chk("w26_not_yet", s_out_valid, 0);
        chk("w64_valid", t_out_valid, 1);
        chk("w64_sum", t_sum, 0);
        chk("w64_cout", t_cout, 1);
        t_a = 64'd5; t_b = 64'd7; t_cin = 1; t_sub = 1;
        @(posedge clk); #1;
        t_in_valid = 0;
        chk("w26_valid", s_out_valid, 1);
        chk("w26_sum", s_sum, 0);
        chk("w26_cout", s_cout, 1);
        chk("w64_sub_sum", t_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("w64_sub_cout", t_cout, 0);
        @(posedge clk); #1;
        chk("w64_idle", t_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
